// File: rtl/uart_pkg.sv
// Shared UART types: parity modes, receiver FSM states and line-rate limits.
package uart_pkg;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      EVEN = 2'd1,
      ODD  = 2'd2,
      RSVD = 2'd3
   } parity_mode_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_e;

   localparam int UART_MIN_CPB = 4;

   // RSVD behaves exactly like NONE: no parity slot in the frame.
   function automatic logic parity_enabled(input parity_mode_e mode);
      return (mode == EVEN) || (mode == ODD);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability chain for the asynchronous rx pin plus falling-edge detect
// on the synchronised line. All stages reset to the idle (high) level.
module uart_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   output logic rxs,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic [SYNC_STAGES-1:0] sync_next;
   logic                   rxs_prev_reg;

   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign sync_next[gi] = rx;
         end else begin : g_chain
            assign sync_next[gi] = sync_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg     <= '1;
         rxs_prev_reg <= 1'b1;
      end else begin
         sync_reg     <= sync_next;
         rxs_prev_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign rxs  = sync_reg[SYNC_STAGES-1];
   assign fall = rxs_prev_reg & ~rxs;

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: configurable width, parity, stop bits, break
// recovery, overrun flag and valid/ready output. UART_RX_MAJORITY_EN selects 3-sample voting.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int CPB_W       = 13,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx,
   input  logic [CPB_W-1:0]  clk_per_bit,
   input  logic [1:0]        parity_mode,
   input  logic              stop_bits,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              frame_error,
   output logic              parity_error,
   output logic              overrun_error,
   output logic              busy
);

   localparam int BIT_W = $clog2(DATA_W + 1);

   logic rxs;
   logic fall;

   uart_rx_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .rx   (rx),
      .rxs  (rxs),
      .fall (fall)
   );

   rx_state_e          state_reg, state_next;
   logic [CPB_W-1:0]   cnt_reg, cnt_next;
   logic [CPB_W-1:0]   cpb_reg, cpb_next;
   parity_mode_e       par_reg, par_next;
   logic               two_stop_reg, two_stop_next;
   logic [BIT_W-1:0]   bit_idx_reg, bit_idx_next;
   logic               stop_idx_reg, stop_idx_next;
   logic [DATA_W-1:0]  shift_reg, shift_next;
   logic               perr_acc_reg, perr_acc_next;
   logic               ferr_acc_reg, ferr_acc_next;
   logic [DATA_W-1:0]  rx_data_reg, rx_data_next;
   logic               rx_valid_reg, rx_valid_next;
   logic               frame_err_reg, frame_err_next;
   logic               parity_err_reg, parity_err_next;
   logic               overrun_reg, overrun_next;

   logic [CPB_W-1:0]   half;
   logic [CPB_W-1:0]   cnt_inc;
   logic               slot_end;
   logic               sample_tick;
   logic               sample_bit;
   logic               complete;
   logic               ferr_final;

   assign half     = cpb_reg >> 1;
   assign slot_end = (cnt_reg == cpb_reg - CPB_W'(1));
   assign cnt_inc  = slot_end ? '0 : cnt_reg + CPB_W'(1);

`ifdef UART_RX_MAJORITY_EN
   // hist_reg[1] holds rxs at half-1 and hist_reg[0] at half when cnt reaches half+1.
   logic [1:0] hist_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hist_reg <= 2'b11;
      else        hist_reg <= {hist_reg[0], rxs};
   end

   assign sample_tick = (cnt_reg == half + CPB_W'(1));
   assign sample_bit  = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & rxs) | (hist_reg[0] & rxs);
`else
   assign sample_tick = (cnt_reg == half);
   assign sample_bit  = rxs;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         cpb_reg        <= CPB_W'(UART_MIN_CPB);
         par_reg        <= NONE;
         two_stop_reg   <= 1'b0;
         bit_idx_reg    <= '0;
         stop_idx_reg   <= 1'b0;
         shift_reg      <= '0;
         perr_acc_reg   <= 1'b0;
         ferr_acc_reg   <= 1'b0;
         rx_data_reg    <= '0;
         rx_valid_reg   <= 1'b0;
         frame_err_reg  <= 1'b0;
         parity_err_reg <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         cpb_reg        <= cpb_next;
         par_reg        <= par_next;
         two_stop_reg   <= two_stop_next;
         bit_idx_reg    <= bit_idx_next;
         stop_idx_reg   <= stop_idx_next;
         shift_reg      <= shift_next;
         perr_acc_reg   <= perr_acc_next;
         ferr_acc_reg   <= ferr_acc_next;
         rx_data_reg    <= rx_data_next;
         rx_valid_reg   <= rx_valid_next;
         frame_err_reg  <= frame_err_next;
         parity_err_reg <= parity_err_next;
         overrun_reg    <= overrun_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      cpb_next        = cpb_reg;
      par_next        = par_reg;
      two_stop_next   = two_stop_reg;
      bit_idx_next    = bit_idx_reg;
      stop_idx_next   = stop_idx_reg;
      shift_next      = shift_reg;
      perr_acc_next   = perr_acc_reg;
      ferr_acc_next   = ferr_acc_reg;
      rx_data_next    = rx_data_reg;
      rx_valid_next   = rx_valid_reg;
      frame_err_next  = frame_err_reg;
      parity_err_next = parity_err_reg;
      overrun_next    = 1'b0;
      complete        = 1'b0;
      ferr_final      = ferr_acc_reg;

      case (state_reg)
         IDLE: begin
            if (fall) begin
               // Configuration is frozen here for the whole frame.
               cpb_next      = (clk_per_bit < CPB_W'(UART_MIN_CPB)) ? CPB_W'(UART_MIN_CPB)
                                                                     : clk_per_bit;
               par_next      = parity_mode_e'(parity_mode);
               two_stop_next = stop_bits;
               cnt_next      = '0;
               bit_idx_next  = '0;
               stop_idx_next = 1'b0;
               perr_acc_next = 1'b0;
               ferr_acc_next = 1'b0;
               state_next    = START;
            end
         end
         START: begin
            cnt_next = cnt_inc;
            if (sample_tick && sample_bit) state_next = IDLE;
            else if (slot_end)             state_next = DATA;
         end
         DATA: begin
            cnt_next = cnt_inc;
            if (sample_tick) begin
               shift_next   = {sample_bit, shift_reg[DATA_W-1:1]};
               bit_idx_next = bit_idx_reg + BIT_W'(1);
            end
            if (slot_end && bit_idx_reg == BIT_W'(DATA_W))
               state_next = parity_enabled(par_reg) ? PARITY : STOP;
         end
         PARITY: begin
            cnt_next = cnt_inc;
            if (sample_tick)
               perr_acc_next = sample_bit != ((^shift_reg) ^ (par_reg == ODD));
            if (slot_end) state_next = STOP;
         end
         STOP: begin
            cnt_next = cnt_inc;
            if (sample_tick) begin
               ferr_final    = ferr_acc_reg | ~sample_bit;
               ferr_acc_next = ferr_final;
               if (stop_idx_reg == two_stop_reg) begin
                  complete   = 1'b1;
                  state_next = rxs ? IDLE : BREAK;
               end
            end else if (slot_end) begin
               stop_idx_next = 1'b1;
            end
         end
         BREAK: begin
            if (rxs) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // A word held unaccepted blocks the new one; a same-cycle accept frees the slot.
      if (complete) begin
         if (!rx_valid_reg || rx_ready) begin
            rx_data_next    = shift_reg;
            parity_err_next = perr_acc_reg;
            frame_err_next  = ferr_final;
            rx_valid_next   = 1'b1;
         end else begin
            overrun_next = 1'b1;
         end
      end else if (rx_valid_reg && rx_ready) begin
         rx_valid_next = 1'b0;
      end
   end

   assign rx_data       = rx_data_reg;
   assign rx_valid      = rx_valid_reg;
   assign frame_error   = frame_err_reg;
   assign parity_error  = parity_err_reg;
   assign overrun_error = overrun_reg;
   assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: table vectors, hand corner sequences
// and randomized frames checked against a frame-level reference model.
module tb_uart_rx_frame;

   localparam int DATA_W = 8;
   localparam int CPB_W  = 13;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rx = 1'b1;
   logic [CPB_W-1:0]  clk_per_bit = 13'd16;
   logic [1:0]        parity_mode = 2'd0;
   logic              stop_bits = 1'b0;
   logic              rx_ready = 1'b1;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              frame_error;
   logic              parity_error;
   logic              overrun_error;
   logic              busy;

   always #5 clk = ~clk;

   uart_rx_frame #(
      .DATA_W(DATA_W),
      .CPB_W(CPB_W),
      .SYNC_STAGES(2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx),
      .clk_per_bit  (clk_per_bit),
      .parity_mode  (parity_mode),
      .stop_bits    (stop_bits),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .frame_error  (frame_error),
      .parity_error (parity_error),
      .overrun_error(overrun_error),
      .busy         (busy)
   );

   typedef struct {
      logic [7:0] data;
      int         pmode;
      bit         two_stop;
      bit         flip_par;
      bit         bad_stop;
      int         cpb;
      logic [7:0] exp_data;
      bit         exp_perr;
      bit         exp_ferr;
   } vec_t;

   vec_t tbl [6];

   int n_cmp = 0;
   int n_err = 0;

   // Monitor: record every accepted word, count valid cycles and overrun pulses.
   logic [9:0] got_arr [0:255];
   int got_wr  = 0;
   int vld_cyc = 0;
   int ovr_cnt = 0;
   int got_rd  = 0;
   int vld_mark = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid) vld_cyc <= vld_cyc + 1;
         if (rx_valid && rx_ready) begin
            got_arr[got_wr % 256] <= {parity_error, frame_error, rx_data};
            got_wr <= got_wr + 1;
         end
         if (overrun_error) ovr_cnt <= ovr_cnt + 1;
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rx = 1'b1;
      end
   endtask

   // Drives one frame, each slot held cpb cycles; glitch forces one cycle low.
   task automatic send_frame(input logic [7:0] data, input int pmode, input bit two_stop,
                             input bit flip_par, input bit bad_stop, input int cpb,
                             input int glitch, input bit scramble);
      bit line[$];
      bit par;
      int off;
      line.push_back(1'b0);
      for (int i = 0; i < 8; i++) line.push_back(data[i]);
      if (pmode == 1 || pmode == 2) begin
         par = (pmode == 1) ? ^data : ~^data;
         line.push_back(par ^ flip_par);
      end
      if (two_stop) line.push_back(1'b1);
      line.push_back(!bad_stop);
      clk_per_bit = CPB_W'(cpb);
      parity_mode = pmode[1:0];
      stop_bits   = two_stop;
      for (int s = 0; s < line.size(); s++) begin
         for (int k = 0; k < cpb; k++) begin
            @(negedge clk);
            off = s * cpb + k;
            rx  = (off == glitch) ? 1'b0 : line[s];
            if (scramble && off == 5) begin
               clk_per_bit = CPB_W'($urandom_range(4, 40));
               parity_mode = 2'($urandom_range(0, 3));
               stop_bits   = 1'($urandom_range(0, 1));
            end
         end
      end
   endtask

   task automatic expect_frame(input string name, input logic [7:0] d, input bit pe, input bit fe);
      logic [9:0] e;
      check({name, " word_count"}, got_wr - got_rd, 1);
      check({name, " valid_cycles"}, vld_cyc - vld_mark, 1);
      if (got_wr > got_rd) begin
         e = got_arr[got_rd % 256];
         check({name, " rx_data"}, e[7:0], d);
         check({name, " parity_error"}, e[9], pe);
         check({name, " frame_error"}, e[8], fe);
         $display("frame %s: data=%02h perr=%0d ferr=%0d (exp %02h %0d %0d)",
                  name, e[7:0], e[9], e[8], d, pe, fe);
      end
      got_rd   = got_wr;
      vld_mark = vld_cyc;
   endtask

   initial begin
      logic [7:0] rdata;
      int         rpmode;
      bit         rts, rflip, rbad;
      int         rcpb;
      int         ovr_base;
      logic [7:0] maj_exp;

      tbl[0] = '{8'hA5, 0, 1'b0, 1'b0, 1'b0, 16, 8'hA5, 1'b0, 1'b0};
      tbl[1] = '{8'h03, 1, 1'b0, 1'b1, 1'b0, 16, 8'h03, 1'b1, 1'b0};
      tbl[2] = '{8'h3C, 2, 1'b0, 1'b0, 1'b0,  8, 8'h3C, 1'b0, 1'b0};
      tbl[3] = '{8'hC1, 2, 1'b1, 1'b1, 1'b0,  4, 8'hC1, 1'b1, 1'b0};
      tbl[4] = '{8'h7E, 3, 1'b0, 1'b1, 1'b0, 12, 8'h7E, 1'b0, 1'b0};
      tbl[5] = '{8'h80, 1, 1'b1, 1'b0, 1'b1, 16, 8'h80, 1'b0, 1'b1};

      repeat (3) @(negedge clk);
      check("reset rx_data", rx_data, 0);
      check("reset rx_valid", rx_valid, 0);
      check("reset frame_error", frame_error, 0);
      check("reset parity_error", parity_error, 0);
      check("reset overrun_error", overrun_error, 0);
      check("reset busy", busy, 0);
      rst_n = 1'b1;
      idle(5);

      for (int i = 0; i < 6; i++) begin
         send_frame(tbl[i].data, tbl[i].pmode, tbl[i].two_stop, tbl[i].flip_par,
                    tbl[i].bad_stop, tbl[i].cpb, -1, 1'b0);
         idle(32);
         expect_frame($sformatf("table%0d", i), tbl[i].exp_data, tbl[i].exp_perr, tbl[i].exp_ferr);
      end

      // Bad second stop then a long low line: one word, stay in BREAK until rx returns high.
      send_frame(8'h5A, 0, 1'b1, 1'b0, 1'b1, 16, -1, 1'b0);
      repeat (640) @(negedge clk);
      check("break busy_while_low", busy, 1);
      expect_frame("break", 8'h5A, 1'b0, 1'b1);
      idle(40);
      check("break busy_after_high", busy, 0);
      check("break no_extra_word", got_wr - got_rd, 0);

      // Short low pulse: false start.
      clk_per_bit = 13'd16;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         rx = 1'b0;
      end
      check("false_start busy_mid", busy, 1);
      idle(40);
      check("false_start busy_end", busy, 0);
      check("false_start no_word", got_wr - got_rd, 0);
      $display("false start: busy=%0d words=%0d", busy, got_wr - got_rd);

      // Back-to-back frames with consumer stalled: second one is dropped.
      rx_ready = 1'b0;
      ovr_base = ovr_cnt;
      send_frame(8'h11, 0, 1'b0, 1'b0, 1'b0, 16, -1, 1'b0);
      send_frame(8'h22, 0, 1'b0, 1'b0, 1'b0, 16, -1, 1'b0);
      idle(32);
      check("overrun rx_valid", rx_valid, 1);
      check("overrun rx_data_held", rx_data, 8'h11);
      check("overrun pulse_count", ovr_cnt - ovr_base, 1);
      $display("overrun: data=%02h pulses=%0d", rx_data, ovr_cnt - ovr_base);
      @(posedge clk);
      #1 rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("overrun accepted_count", got_wr - got_rd, 1);
      if (got_wr > got_rd) check("overrun accepted_word", got_arr[got_rd % 256][7:0], 8'h11);
      check("overrun valid_dropped", rx_valid, 0);
      got_rd   = got_wr;
      vld_mark = vld_cyc;

      // One-cycle low glitch centred on bit 3's sample point.
`ifdef UART_RX_MAJORITY_EN
      maj_exp = 8'hFF;
`else
      maj_exp = 8'hF7;
`endif
      send_frame(8'hFF, 0, 1'b0, 1'b0, 1'b0, 16, 4 * 16 + 16 / 2 + 1, 1'b0);
      idle(32);
      expect_frame("glitch", maj_exp, 1'b0, 1'b0);

      // Random frames with config inputs scrambled mid-frame.
      for (int i = 0; i < 24; i++) begin
         rdata  = 8'($urandom);
         rpmode = $urandom_range(0, 3);
         rts    = 1'($urandom_range(0, 1));
         rflip  = 1'($urandom_range(0, 1));
         rbad   = 1'($urandom_range(0, 3) == 0);
         rcpb   = $urandom_range(4, 12);
         send_frame(rdata, rpmode, rts, rflip, rbad, rcpb, -1, 1'b1);
         idle(2 * rcpb + 4);
         expect_frame($sformatf("rand%0d", i), rdata,
                      (rpmode == 1 || rpmode == 2) && rflip, rbad);
      end

      // Reset in the middle of a frame abandons it.
      clk_per_bit = 13'd16;
      parity_mode = 2'd0;
      stop_bits   = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         rx = (k < 16) ? 1'b0 : 1'b1;
      end
      check("midreset busy_before", busy, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset busy_async", busy, 0);
      check("midreset rx_valid", rx_valid, 0);
      idle(3);
      rst_n = 1'b1;
      idle(200);
      check("midreset no_word", got_wr - got_rd, 0);
      check("midreset busy_after", busy, 0);
      $display("mid-frame reset: busy=%0d words=%0d", busy, got_wr - got_rd);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
